// File: rtl/fsm1_pkg.sv
// Shared fsm1 types: initiator and responder state encodings for the rd/ws/ds read handshake.
package fsm1_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DLY  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // RXX is the spare encoding; the responder never enters it.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RDY  = 2'd2,
        RXX    = 2'd3
    } resp_state_e;

endpackage

// File: rtl/fsm1_resp.sv
// fsm1 read-cycle responder: stretches the initiator's read with ws, then presents rdata until ds.
// Optional protocol checker on err enabled by defining FSM1_RESP_CHECK_EN.
module fsm1_resp
    import fsm1_pkg::*;
#(
    parameter int unsigned       WAIT_W    = 4,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] DATA_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              ds,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              ws,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err
);

    // rem holds 2N: one READ and one DLY cycle per wait sample.
    localparam int unsigned REM_W = WAIT_W + 1;

    resp_state_e       state;
    resp_state_e       state_n;
    logic [REM_W-1:0]  rem;
    logic [REM_W-1:0]  rem_n;
    logic [REM_W-1:0]  rem_dec;
    logic [DATA_W-1:0] rdata_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= R_IDLE;
            rem   <= '0;
            rdata <= DATA_INIT;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            rdata <= rdata_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        rdata_n = rdata;
        rem_dec = rem - REM_W'(1);
        case (state)
            R_IDLE: begin
                if (rd) begin
                    rem_n   = {wait_cfg, 1'b0};
                    state_n = (wait_cfg == '0) ? R_RDY : R_WAIT;
                end
            end
            R_WAIT: begin
                if (!rd) begin
                    state_n = R_IDLE;
                end else begin
                    rem_n = rem_dec;
                    if (rem_dec == '0) begin
                        state_n = R_RDY;
                    end
                end
            end
            R_RDY: begin
                if (ds) begin
                    state_n = R_IDLE;
                    rdata_n = rdata + DATA_W'(1);
                end
            end
            default: begin
                state_n = resp_state_e'('x);
                rem_n   = 'x;
                rdata_n = 'x;
            end
        endcase
    end

    // Outputs are the registered decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws     <= 1'b0;
            rvalid <= 1'b0;
        end else begin
            ws     <= (state_n == R_WAIT);
            rvalid <= (state_n == R_RDY);
        end
    end

`ifdef FSM1_RESP_CHECK_EN
    logic err_n;

    assign err_n = (ds && ((state == R_IDLE) || (state == R_WAIT)))
                 || (!rd && (state == R_WAIT))
                 || (rd && ds);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fsm1_resp.sv
// Testbench for fsm1_resp: paired with a behavioural fsm1 initiator plus standalone abort/stray-ds stimulus.
module tb_fsm1_resp;
    import fsm1_pkg::*;

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned DATA_W = 8;
`ifdef FSM1_RESP_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              go;
    logic              paired;
    logic              sa_rd;
    logic              sa_ds;
    logic [WAIT_W-1:0] wait_cfg;
    logic              rd;
    logic              ds;
    logic              ws;
    logic              rvalid;
    logic              err;
    logic [DATA_W-1:0] rdata;

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] model_rdata;
    logic [DATA_W-1:0] exp_q[$];
    state_e            ini_st;

    always #5 clk = ~clk;

    // Behavioural fsm1 initiator: READ/DLY loop while ws, DONE pulses ds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ini_st <= S_IDLE;
        end else begin
            case (ini_st)
                S_IDLE:  ini_st <= go ? S_READ : S_IDLE;
                S_READ:  ini_st <= S_DLY;
                S_DLY:   ini_st <= ws ? S_READ : S_DONE;
                S_DONE:  ini_st <= go ? S_READ : S_IDLE;
                default: ini_st <= S_IDLE;
            endcase
        end
    end

    assign rd = paired ? ((ini_st == S_READ) || (ini_st == S_DLY)) : sa_rd;
    assign ds = paired ? (ini_st == S_DONE) : sa_ds;

    fsm1_resp #(
        .WAIT_W    (WAIT_W),
        .DATA_W    (DATA_W),
        .DATA_INIT (8'd0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd       (rd),
        .ds       (ds),
        .wait_cfg (wait_cfg),
        .ws       (ws),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .err      (err)
    );

    // Caller has set go=1 and wait_cfg=n at the negedge of cycle t-1.
    task automatic do_read(input int n, input int cfg_mid, input bit keep_go);
        logic [DATA_W-1:0] exp;
        logic              exp_ws;
        logic              exp_rv;
        exp_q.push_back(model_rdata);
        model_rdata = model_rdata + 8'd1;
        for (int k = 0; k <= 2 * n + 2; k++) begin
            @(negedge clk);
            if (k == 0 && !keep_go) go = 1'b0;
            if (k == 1) wait_cfg = WAIT_W'(cfg_mid);
            exp_ws = (k >= 1) && (k <= 2 * n);
            exp_rv = (k >= 2 * n + 1);
            checks++;
            if (ws !== exp_ws) begin
                errors++;
                $display("FAIL read_ws n=%0d k=%0d got %b want %b", n, k, ws, exp_ws);
            end
            checks++;
            if (rvalid !== exp_rv) begin
                errors++;
                $display("FAIL read_rvalid n=%0d k=%0d got %b want %b", n, k, rvalid, exp_rv);
            end
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL read_err n=%0d k=%0d got %b want 0", n, k, err);
            end
            if (k == 2 * n + 2) begin
                exp = exp_q.pop_front();
                checks++;
                if (rdata !== exp) begin
                    errors++;
                    $display("FAIL read_rdata n=%0d got %0d want %0d", n, rdata, exp);
                end
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (ws !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle ws=%b rvalid=%b want 0 0", name, ws, rvalid);
        end
        checks++;
        if (rdata !== model_rdata) begin
            errors++;
            $display("FAIL %s_rdata got %0d want %0d", name, rdata, model_rdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; go = 1'b0; paired = 1'b0; sa_rd = 1'b0; sa_ds = 1'b0;
        wait_cfg = 4'd3; model_rdata = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ws !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 8'd0) begin
                errors++;
                $display("FAIL reset i=%0d ws=%b rvalid=%b err=%b rdata=%0d want 0 0 0 0",
                         i, ws, rvalid, err, rdata);
            end
        end
    endtask

    task automatic test_paired(input int n);
        @(negedge clk);
        paired = 1'b1; wait_cfg = WAIT_W'(n); go = 1'b1;
        do_read(n, n, 1'b0);
        check_idle("paired");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        paired = 1'b1; wait_cfg = 4'd1; go = 1'b1;
        do_read(1, 3, 1'b1);
        do_read(3, 3, 1'b0);
        check_idle("b2b");
    endtask

    task automatic test_abort();
        @(negedge clk);
        paired = 1'b0; wait_cfg = 4'd4; sa_rd = 1'b1;
        @(negedge clk);
        sa_rd = 1'b0;
        checks++;
        if (ws !== 1'b1) begin
            errors++;
            $display("FAIL abort_ws_start got %b want 1", ws);
        end
        check_idle("abort");
        checks++;
        if (err !== CHK) begin
            errors++;
            $display("FAIL abort_err got %b want %b", err, CHK);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_clear got %b want 0", err);
        end
        sa_ds = 1'b1;
        @(negedge clk);
        sa_ds = 1'b0;
        checks++;
        if (err !== CHK || rvalid !== 1'b0 || rdata !== model_rdata) begin
            errors++;
            $display("FAIL stray_ds err=%b rvalid=%b rdata=%0d want %b 0 %0d",
                     err, rvalid, rdata, CHK, model_rdata);
        end
        check_idle("stray_ds");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        paired = 1'b1; wait_cfg = 4'd5; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ws !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ws_before got %b want 1", ws);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ws !== 1'b0 || rvalid !== 1'b0 || rdata !== 8'd0) begin
            errors++;
            $display("FAIL midrst_async ws=%b rvalid=%b rdata=%0d want 0 0 0", ws, rvalid, rdata);
        end
        model_rdata = 8'd0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_cfg = 4'd1; go = 1'b1;
        do_read(1, 1, 1'b0);
        check_idle("midrst");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        paired = 1'b1; wait_cfg = 4'd0; go = 1'b1;
        for (int i = 0; i < 256; i++) begin
            do_read(0, 0, i < 255);
        end
        check_idle("wrap");
    endtask

    initial begin
        test_reset();
        test_paired(0);
        test_paired(2);
        test_back_to_back();
        test_abort();
        test_mid_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
